// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for the 8-entry fifo: waits for a full burst (or a
// timeout / flush for a partial one), then drains it onto a valid/ready stream.
module fifo_burst_reader #(
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 15,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              hresetn,
  input  logic              enable,
  input  logic              flush,
  input  logic [3:0]        fifo_count,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dataout,
  output logic              fifo_read,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              underrun
);

  localparam logic [3:0] BURST_LEN_W = 4'(BURST_LEN);
  localparam logic [7:0] TIMEOUT_W   = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [7:0]          timer_reg, timer_next;
  logic [3:0]          beats_reg, beats_next;
  logic                valid_reg, valid_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                last_reg, last_next;
  logic                underrun_reg, underrun_next;
  logic                slot_free;

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state_reg    <= ST_IDLE;
      timer_reg    <= '0;
      beats_reg    <= '0;
      valid_reg    <= 1'b0;
      data_reg     <= '0;
      last_reg     <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      beats_reg    <= beats_next;
      valid_reg    <= valid_next;
      data_reg     <= data_next;
      last_reg     <= last_next;
      underrun_reg <= underrun_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    beats_next    = beats_reg;
    valid_next    = valid_reg;
    data_next     = data_reg;
    last_next     = last_reg;
    underrun_next = 1'b0;

    // The single output stage can take a new word when empty or being drained.
    slot_free = !valid_reg || out_ready;
    fifo_read = (state_reg == ST_BURST) && (beats_reg != 4'd0) && !fifo_empty && slot_free;

    case (state_reg)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          state_next = ST_WAIT;
          timer_next = TIMEOUT_W;
        end
      end
      ST_WAIT: begin
        if (fifo_empty) begin
          state_next = ST_IDLE;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end else if (fifo_count >= BURST_LEN_W) begin
          state_next = ST_BURST;
          beats_next = BURST_LEN_W;
        end else if (flush || (timer_reg == 8'd0)) begin
          // Partial burst: only what is queued right now belongs to it.
          state_next = ST_BURST;
          beats_next = fifo_count;
        end else begin
          timer_next = timer_reg - 8'd1;
        end
      end
      ST_BURST: begin
        if (fifo_read) begin
          beats_next = beats_reg - 4'd1;
        end else if ((beats_reg != 4'd0) && fifo_empty) begin
          // Fifo vanished under us: abandon the rest of the burst without a last marker.
          underrun_next = 1'b1;
          beats_next    = 4'd0;
        end else if ((beats_reg == 4'd0) && slot_free) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if (fifo_read) begin
      data_next  = fifo_dataout;
      valid_next = 1'b1;
      last_next  = (beats_reg == 4'd1);
    end else if (valid_reg && out_ready) begin
      valid_next = 1'b0;
      last_next  = 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_last  = last_reg;
  assign underrun  = underrun_reg;
  assign busy      = (state_reg != ST_IDLE) || valid_reg;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural fifo plus an expected-word queue
// derived from burst-size arithmetic, with random data and backpressure.
module tb_fifo_burst_reader;

  localparam int BL  = 4;
  localparam int TO  = 15;
  localparam int DW  = 32;

  logic          clk = 1'b0;
  logic          hresetn;
  logic          enable;
  logic          flush;
  logic [3:0]    fifo_count;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dataout;
  logic          fifo_read;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          underrun;

  fifo_burst_reader #(.BURST_LEN(BL), .TIMEOUT(TO), .DATA_W(DW)) dut (
    .clk(clk), .hresetn(hresetn), .enable(enable), .flush(flush),
    .fifo_count(fifo_count), .fifo_empty(fifo_empty), .fifo_dataout(fifo_dataout),
    .fifo_read(fifo_read), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Behavioural 8-entry fifo: head combinational, pops on the clock edge.
  logic [DW-1:0] mem [0:7];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          fifo_clr = 1'b0;
  int            pop_cnt = 0;
  int            ur_cnt = 0;

  assign fifo_count   = 4'(wr_ptr - rd_ptr);
  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_dataout = mem[rd_ptr[2:0]];

  always @(posedge clk) begin
    if (fifo_clr) rd_ptr <= wr_ptr;
    else if (fifo_read) rd_ptr <= rd_ptr + 1;
    if (fifo_read) pop_cnt <= pop_cnt + 1;
    if (underrun) ur_cnt <= ur_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  logic [DW-1:0] exp_data [$];
  logic          exp_last [$];
  int            cyc = 0;
  int            rx_cnt = 0;
  int            stall_left = 0;
  bit            stall_done = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  bit            have_hs = 0;
  bit            prev_hs_last = 0;
  int            prev_hs_cyc = 0;

  task automatic push_word(input logic [DW-1:0] d, input logic last);
    mem[wr_ptr[2:0]] = d;
    wr_ptr++;
    exp_data.push_back(d);
    exp_last.push_back(last);
  endtask

  task automatic clear_monitor();
    exp_data.delete();
    exp_last.delete();
    rx_cnt = 0; stall_left = 0; stall_done = 0;
    prev_stall = 0; have_hs = 0; prev_hs_last = 0;
  endtask

  // One clock of stimulus + checking. mode 0: ready=1, 1: random ready,
  // 2: ready held low for 5 cycles while the second word is presented.
  task automatic step(input int mode);
    @(negedge clk);
    if (mode == 2 && out_valid && rx_cnt == 1 && !stall_done) begin
      stall_left = 5;
      stall_done = 1;
    end
    if (mode == 1) out_ready = 1'($urandom_range(0, 1));
    else if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else out_ready = 1'b1;
    #1;
    cyc++;
    if (prev_stall) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", out_data, prev_data);
      check("hold_last", 32'(out_last), 32'(prev_last));
    end
    if (out_valid && !out_ready) check("read_in_stall", 32'(fifo_read), 32'd0);
    if (fifo_empty) check("read_on_empty", 32'(fifo_read), 32'd0);
    if (out_valid && out_ready) begin
      if (exp_data.size() == 0) check("extra_word", 32'(out_valid), 32'd0);
      else begin
        check("data", out_data, exp_data.pop_front());
        check("last", 32'(out_last), 32'(exp_last.pop_front()));
      end
      if (mode == 0 && have_hs && !prev_hs_last) check("back_to_back", 32'(cyc), 32'(prev_hs_cyc + 1));
      have_hs = 1;
      prev_hs_last = out_last;
      prev_hs_cyc = cyc;
      rx_cnt++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
  endtask

  // Preload n words, enable, and expect bursts of BL followed by one partial burst.
  task automatic run_burst(input int n, input bit use_flush, input int mode, input string name);
    int rem, b, start_cyc, pops0, exp_lat, guard;
    bit seen;
    clear_monitor();
    rem = n;
    while (rem > 0) begin
      b = (rem >= BL) ? BL : rem;
      for (int i = 0; i < b; i++) push_word($urandom, (i == b - 1));
      rem -= b;
    end
    exp_lat = (n >= BL || use_flush) ? 3 : TO + 3;
    pops0 = pop_cnt;
    enable = 1'b1;
    flush = use_flush;
    start_cyc = cyc;
    seen = 0;
    guard = 0;
    while (rx_cnt < n && guard < 400) begin
      step(mode);
      guard++;
      if (!seen && out_valid) begin
        seen = 1;
        check({name, "_latency"}, 32'(cyc - start_cyc), 32'(exp_lat));
      end
    end
    check({name, "_words"}, 32'(rx_cnt), 32'(n));
    step(mode);
    step(mode);
    check({name, "_busy_end"}, 32'(busy), 32'd0);
    check({name, "_pops"}, 32'(pop_cnt - pops0), 32'(n));
    check({name, "_fifo_left"}, 32'(fifo_count), 32'd0);
    enable = 1'b0;
    flush = 1'b0;
    step(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int ur0, guard, n;
    bit fl;
    hresetn = 1'b0; enable = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_read", 32'(fifo_read), 32'd0);
    hresetn = 1'b1;
    step(0);

    run_burst(8, 0, 0, "t1_full");
    run_burst(2, 0, 0, "t2_timeout");
    run_burst(1, 1, 0, "t3_flush");
    run_burst(4, 0, 2, "t4_stall");

    for (int it = 0; it < 12; it++) begin
      n  = $urandom_range(1, 8);
      fl = 1'($urandom_range(0, 1));
      $display("random run %0d: words=%0d flush=%0d", it, n, fl);
      run_burst(n, fl, 1, "rand");
    end

    // Fifo cleared externally while two beats of a full burst remain.
    clear_monitor();
    for (int i = 0; i < 4; i++) begin
      mem[wr_ptr[2:0]] = $urandom;
      if (i < 2) begin
        exp_data.push_back(mem[wr_ptr[2:0]]);
        exp_last.push_back(1'b0);
      end
      wr_ptr++;
    end
    ur0 = ur_cnt;
    enable = 1'b1;
    guard = 0;
    while (!out_valid && guard < 20) begin
      step(0);
      guard++;
    end
    check("t5_started", 32'(out_valid), 32'd1);
    fifo_clr = 1'b1;
    step(0);
    fifo_clr = 1'b0;
    repeat (6) step(0);
    check("t5_underrun_pulses", 32'(ur_cnt - ur0), 32'd1);
    check("t5_words_missing", 32'(exp_data.size()), 32'd0);
    check("t5_busy_end", 32'(busy), 32'd0);
    enable = 1'b0;
    step(0);

    // Asynchronous reset while the second word of a burst is presented.
    clear_monitor();
    for (int i = 0; i < 4; i++) push_word($urandom, (i == 3));
    enable = 1'b1;
    guard = 0;
    while (rx_cnt < 1 && guard < 20) begin
      step(0);
      guard++;
    end
    @(posedge clk);
    #2;
    check("t6_word2_valid", 32'(out_valid), 32'd1);
    hresetn = 1'b0;
    #1;
    check("t6_async_valid", 32'(out_valid), 32'd0);
    check("t6_async_busy", 32'(busy), 32'd0);
    check("t6_async_last", 32'(out_last), 32'd0);
    check("t6_async_read", 32'(fifo_read), 32'd0);
    clear_monitor();
    enable = 1'b0;
    fifo_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fifo_clr = 1'b0;
    #1;
    check("t6_in_reset_valid", 32'(out_valid), 32'd0);
    hresetn = 1'b1;
    step(0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    run_burst(4, 0, 0, "t6_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
